// File: rtl/core_sync_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : core_sync_ctrl
// Description : Responder for the inter-core control protocol. Tracks the
//               per-core run state, forwards PC handoffs as load strobes,
//               generates stall counts for paused cores and shared-memory
//               conflicts, and latches a sticky global halt.
// Revision    : 1.0 - initial release
// ============================================================================
module core_sync_ctrl #(
    parameter logic [15:0] BOOT_PC     = 16'h0000,
    parameter logic [1:0]  BOOT_RUN    = 2'b01,
    parameter logic [2:0]  PAUSE_STALL = 3'd6,
    parameter logic [2:0]  RD_STALL    = 3'd3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  pr_1,
    input  logic [2:0]  pr_2,
    input  logic [17:0] pc_out_1,
    input  logic [17:0] pc_out_2,
    input  logic        wen_1,
    input  logic        wen_2,
    input  logic        rd_1,
    input  logic        rd_2,
    input  logic        halt_1,
    input  logic        halt_2,
    input  logic        awake_1,
    input  logic        awake_2,
    output logic [16:0] pc_passed_1,
    output logic [16:0] pc_passed_2,
    output logic [2:0]  stall_num_1,
    output logic [2:0]  stall_num_2,
    output logic [1:0]  run,
    output logic        halt
);

    logic [1:0] r_run;
    logic       r_boot;
    logic       r_halt;

    logic       w_p1_valid;
    logic       w_p2_valid;
    logic [1:0] w_pause;     // bit k: a valid pause targets core k+1
    logic [1:0] w_resume;    // bit k: a valid resume targets core k+1
    logic [1:0] w_run_next;
    logic       w_halt_set;

    // Request decode; an unknown valid bit compares false and so means "no request".
    always_comb begin
        w_p1_valid = 1'b0;
        w_p2_valid = 1'b0;
        w_pause    = 2'b00;
        w_resume   = 2'b00;
        if (pr_1[2] == 1'b1) begin
            w_p1_valid = 1'b1;
        end
        if (pr_2[2] == 1'b1) begin
            w_p2_valid = 1'b1;
        end
        for (int k = 0; k < 2; k++) begin
            if (w_p1_valid && (pr_1[0] == k[0])) begin
                if (pr_1[1] == 1'b1) w_resume[k] = 1'b1;
                else                 w_pause[k]  = 1'b1;
            end
            if (w_p2_valid && (pr_2[0] == k[0])) begin
                if (pr_2[1] == 1'b1) w_resume[k] = 1'b1;
                else                 w_pause[k]  = 1'b1;
            end
        end
    end

    // Next run state per target: core1's request has priority over core2's.
    always_comb begin
        w_run_next = r_run;
        for (int k = 0; k < 2; k++) begin
            if (w_p1_valid && (pr_1[0] == k[0])) begin
                w_run_next[k] = pr_1[1];
            end else if (w_p2_valid && (pr_2[0] == k[0])) begin
                w_run_next[k] = pr_2[1];
            end
        end
    end

    assign w_halt_set = (halt_1 | ~awake_1) & (halt_2 | ~awake_2);

    // State registers: run state, one-cycle boot flag, sticky halt.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_run  <= BOOT_RUN;
            r_boot <= 1'b1;
            r_halt <= 1'b0;
        end else begin
            r_run  <= w_run_next;
            r_boot <= 1'b0;
            if (w_halt_set) begin
                r_halt <= 1'b1;
            end
        end
    end

    // PC handoff routing; core1's handoff wins, boot overrides both outputs.
    always_comb begin
        pc_passed_1 = 17'd0;
        pc_passed_2 = 17'd0;
        if (pc_out_1[17] == 1'b1 && pc_out_1[16] == 1'b0) begin
            pc_passed_1 = {1'b1, pc_out_1[15:0]};
        end else if (pc_out_2[17] == 1'b1 && pc_out_2[16] == 1'b0) begin
            pc_passed_1 = {1'b1, pc_out_2[15:0]};
        end
        if (pc_out_1[17] == 1'b1 && pc_out_1[16] == 1'b1) begin
            pc_passed_2 = {1'b1, pc_out_1[15:0]};
        end else if (pc_out_2[17] == 1'b1 && pc_out_2[16] == 1'b1) begin
            pc_passed_2 = {1'b1, pc_out_2[15:0]};
        end
        if (r_boot) begin
            pc_passed_1 = {1'b1, BOOT_PC};
            pc_passed_2 = 17'd0;
        end
    end

    // Stall generation; memory-port conflicts always stall core2 only.
    always_comb begin
        stall_num_1 = 3'd0;
        stall_num_2 = 3'd0;
        if (w_pause[0]) begin
            stall_num_1 = PAUSE_STALL;
        end else if (!r_run[0] && !w_resume[0]) begin
            stall_num_1 = PAUSE_STALL;
        end
        if (w_pause[1]) begin
            stall_num_2 = PAUSE_STALL;
        end else if (!r_run[1] && !w_resume[1]) begin
            stall_num_2 = PAUSE_STALL;
        end else if (wen_1 && wen_2) begin
            stall_num_2 = PAUSE_STALL;
        end else if (rd_1 && rd_2) begin
            stall_num_2 = RD_STALL;
        end
    end

    assign run  = r_run;
    assign halt = r_halt;

endmodule
`default_nettype wire

// File: tb/tb_core_sync_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_core_sync_ctrl
// Description : Self-checking bench for core_sync_ctrl using a vector table
//               plus directed sequences for reset, boot and halt behaviour.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_core_sync_ctrl;

    logic        clk;
    logic        reset;
    logic [2:0]  pr_1, pr_2;
    logic [17:0] pc_out_1, pc_out_2;
    logic        wen_1, wen_2, rd_1, rd_2;
    logic        halt_1, halt_2, awake_1, awake_2;
    logic [16:0] pc_passed_1, pc_passed_2;
    logic [2:0]  stall_num_1, stall_num_2;
    logic [1:0]  run;
    logic        halt;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [2:0]  p1;
        logic [2:0]  p2;
        logic [17:0] o1;
        logic [17:0] o2;
        logic        w1;
        logic        w2;
        logic        r1;
        logic        r2;
        logic [16:0] e_pp1;
        logic [16:0] e_pp2;
        logic [2:0]  e_s1;
        logic [2:0]  e_s2;
        logic [1:0]  e_run;   // run after the clock edge
    } vec_t;

    vec_t tbl[11];

    core_sync_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .pr_1        (pr_1),
        .pr_2        (pr_2),
        .pc_out_1    (pc_out_1),
        .pc_out_2    (pc_out_2),
        .wen_1       (wen_1),
        .wen_2       (wen_2),
        .rd_1        (rd_1),
        .rd_2        (rd_2),
        .halt_1      (halt_1),
        .halt_2      (halt_2),
        .awake_1     (awake_1),
        .awake_2     (awake_2),
        .pc_passed_1 (pc_passed_1),
        .pc_passed_2 (pc_passed_2),
        .stall_num_1 (stall_num_1),
        .stall_num_2 (stall_num_2),
        .run         (run),
        .halt        (halt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        // Idle stimulus; awake=1/halt=0 keeps the halt condition false.
        reset = 1'b1;
        pr_1 = 3'b000; pr_2 = 3'b000;
        pc_out_1 = 18'd0; pc_out_2 = 18'd0;
        wen_1 = 1'b0; wen_2 = 1'b0; rd_1 = 1'b0; rd_2 = 1'b0;
        halt_1 = 1'b0; halt_2 = 1'b0; awake_1 = 1'b1; awake_2 = 1'b1;

        //           p1      p2      o1                    o2                    w1 w2 r1 r2  pp1        pp2        s1    s2    run
        tbl[0]  = '{3'b000, 3'b000, 18'd0,                18'd0,                0, 0, 0, 0, 17'h00000, 17'h00000, 3'd0, 3'd6, 2'b01};
        tbl[1]  = '{3'b111, 3'b000, {2'b11, 16'h0040},    18'd0,                0, 0, 0, 0, 17'h00000, 17'h10040, 3'd0, 3'd0, 2'b11};
        tbl[2]  = '{3'b000, 3'b000, 18'd0,                18'd0,                1, 1, 0, 0, 17'h00000, 17'h00000, 3'd0, 3'd6, 2'b11};
        tbl[3]  = '{3'b000, 3'b000, 18'd0,                18'd0,                1, 0, 1, 1, 17'h00000, 17'h00000, 3'd0, 3'd3, 2'b11};
        tbl[4]  = '{3'b101, 3'b111, 18'd0,                {2'b10, 16'h1234},    0, 0, 0, 0, 17'h11234, 17'h00000, 3'd0, 3'd6, 2'b01};
        tbl[5]  = '{3'b000, 3'b000, {2'b10, 16'hAAAA},    {2'b10, 16'hBBBB},    0, 0, 0, 0, 17'h1AAAA, 17'h00000, 3'd0, 3'd6, 2'b01};
        tbl[6]  = '{3'b100, 3'b111, 18'd0,                {2'b11, 16'h5555},    0, 0, 0, 0, 17'h00000, 17'h15555, 3'd6, 3'd0, 2'b10};
        tbl[7]  = '{3'b000, 3'b000, 18'd0,                18'd0,                0, 0, 0, 0, 17'h00000, 17'h00000, 3'd6, 3'd0, 2'b10};
        tbl[8]  = '{3'b000, 3'b110, 18'd0,                18'd0,                0, 0, 1, 1, 17'h00000, 17'h00000, 3'd0, 3'd3, 2'b11};
        tbl[9]  = '{3'b000, 3'b100, 18'd0,                18'd0,                0, 0, 0, 0, 17'h00000, 17'h00000, 3'd6, 3'd0, 2'b10};
        tbl[10] = '{3'bx11, 3'b011, 18'd0,                18'd0,                0, 0, 0, 0, 17'h00000, 17'h00000, 3'd6, 3'd0, 2'b10};

        // Reset state
        #1;
        chk("rst_run",   32'(run),         32'(2'b01));
        chk("rst_halt",  32'(halt),        32'(1'b0));
        chk("rst_pp1",   32'(pc_passed_1), 32'(17'h10000));
        chk("rst_pp2",   32'(pc_passed_2), 32'(17'h00000));
        chk("rst_s1",    32'(stall_num_1), 32'(3'd0));
        chk("rst_s2",    32'(stall_num_2), 32'(3'd6));

        // Release: boot strobe visible for exactly one cycle
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("boot_pp1",  32'(pc_passed_1), 32'(17'h10000));
        chk("boot_pp2",  32'(pc_passed_2), 32'(17'h00000));
        chk("boot_s2",   32'(stall_num_2), 32'(3'd6));
        chk("boot_run",  32'(run),         32'(2'b01));
        @(posedge clk);
        #1;
        chk("post_boot_pp1", 32'(pc_passed_1), 32'(17'h00000));
        chk("post_boot_run", 32'(run),         32'(2'b01));

        // Vector table
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            pr_1 = tbl[i].p1; pr_2 = tbl[i].p2;
            pc_out_1 = tbl[i].o1; pc_out_2 = tbl[i].o2;
            wen_1 = tbl[i].w1; wen_2 = tbl[i].w2;
            rd_1 = tbl[i].r1; rd_2 = tbl[i].r2;
            #1;
            chk($sformatf("v%0d_pp1", i), 32'(pc_passed_1), 32'(tbl[i].e_pp1));
            chk($sformatf("v%0d_pp2", i), 32'(pc_passed_2), 32'(tbl[i].e_pp2));
            chk($sformatf("v%0d_s1", i),  32'(stall_num_1), 32'(tbl[i].e_s1));
            chk($sformatf("v%0d_s2", i),  32'(stall_num_2), 32'(tbl[i].e_s2));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_run", i), 32'(run), 32'(tbl[i].e_run));
        end

        // Halt: set by halt_1 with core2 not awake; requests still processed
        @(negedge clk);
        pr_1 = 3'b000; pr_2 = 3'b110;
        pc_out_1 = 18'd0; pc_out_2 = 18'd0;
        wen_1 = 1'b0; wen_2 = 1'b0; rd_1 = 1'b0; rd_2 = 1'b0;
        halt_1 = 1'b1; awake_2 = 1'b0;
        #1;
        chk("halt_pre", 32'(halt), 32'(1'b0));
        @(posedge clk);
        #1;
        chk("halt_set",     32'(halt), 32'(1'b1));
        chk("halt_set_run", 32'(run),  32'(2'b11));
        @(negedge clk);
        halt_1 = 1'b0; awake_2 = 1'b1; pr_2 = 3'b000; pr_1 = 3'b100;
        @(posedge clk);
        #1;
        chk("halt_sticky1", 32'(halt), 32'(1'b1));
        chk("halt_req_run", 32'(run),  32'(2'b10));
        @(negedge clk);
        pr_1 = 3'b000;
        @(posedge clk);
        #1;
        chk("halt_sticky2", 32'(halt), 32'(1'b1));
        chk("pre_rst_run",  32'(run),  32'(2'b10));

        // Mid-run asynchronous reset, away from any clock edge
        #2;
        reset = 1'b1;
        #1;
        chk("mid_rst_run",  32'(run),         32'(2'b01));
        chk("mid_rst_halt", 32'(halt),        32'(1'b0));
        chk("mid_rst_pp1",  32'(pc_passed_1), 32'(17'h10000));
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("reboot_pp1", 32'(pc_passed_1), 32'(17'h10000));
        @(posedge clk);
        #1;
        chk("reboot_end_pp1", 32'(pc_passed_1), 32'(17'h00000));
        chk("reboot_run",     32'(run),         32'(2'b01));
        chk("reboot_halt",    32'(halt),        32'(1'b0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
